// File: rtl/expr_stream_eval_pkg.sv
// Shared types for the streaming expression recognizer/evaluator:
// FSM state encoding, token classes and the ASCII codes of the grammar.
package expr_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_NUM   = 2'b01,
    ST_CLOSE = 2'b10,
    ST_ERR   = 2'b11
  } expr_state_t;

  typedef enum logic [2:0] {
    TOK_DIGIT,
    TOK_PLUS,
    TOK_MUL,
    TOK_LP,
    TOK_RP,
    TOK_BAD
  } expr_tok_t;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_MUL  = 8'h2A;
  localparam logic [7:0] ASCII_LP   = 8'h28;
  localparam logic [7:0] ASCII_RP   = 8'h29;

endpackage

// File: rtl/expr_stream_eval_if.sv
// Character stream in, recognizer/evaluator results out.
// Handshake: a character on `in` is consumed at a rising edge only when in_valid=1; there is no backpressure.
interface expr_stream_eval_if #(
  parameter int WIDTH     = 32,
  parameter int MAX_DEPTH = 4
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic [7:0]       in;
  logic             in_valid;
  logic             out;
  logic [1:0]       Status;
  logic [DW-1:0]    depth;
  logic [WIDTH-1:0] value;
  logic             ovf;

  modport master (
    output in, in_valid,
    input  out, Status, depth, value, ovf
  );

  modport slave (
    input  in, in_valid,
    output out, Status, depth, value, ovf
  );
endinterface

// File: rtl/expr_stream_eval_char_class.sv
// Combinational byte classifier: maps one ASCII byte to a token class
// and, for digits, its numeric value.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch,
  output expr_tok_t  tok,
  output logic [3:0] dig
);

  always_comb begin
    tok = TOK_BAD;
    dig = 4'd0;
    if (ch >= ASCII_0 && ch <= ASCII_9) begin
      tok = TOK_DIGIT;
      // '0'..'9' are 0x30..0x39, so the low nibble is the digit value
      dig = ch[3:0];
    end else begin
      case (ch)
        ASCII_PLUS: tok = TOK_PLUS;
        ASCII_MUL:  tok = TOK_MUL;
        ASCII_LP:   tok = TOK_LP;
        ASCII_RP:   tok = TOK_RP;
        default:    tok = TOK_BAD;
      endcase
    end
  end

endmodule

// File: rtl/expr_stream_eval.sv
// Streaming arithmetic-expression recognizer, one character per clock.
// Define EXPR_STREAM_EVAL_EN to also build the evaluation stack (value/ovf).
module expr_stream_eval
  import expr_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              clr,
  expr_stream_eval_if.slave bus
);

  localparam int              DW   = $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0]   DMAX = DW'(MAX_DEPTH);
  localparam logic [DW-1:0]   DONE = DW'(1);

  expr_tok_t     tok;
  logic [3:0]    dig;
  expr_state_t   state, state_nx;
  logic [DW-1:0] depth_q, depth_nx;
  logic          out_q, out_nx;
  logic          accept;

  expr_char_class u_class (
    .ch  (bus.in),
    .tok (tok),
    .dig (dig)
  );

  // Depth only moves on a legal transition, so it freezes on entry to ST_ERR.
  always_comb begin
    state_nx = state;
    depth_nx = depth_q;
    if (bus.in_valid) begin
      case (state)
        ST_START: begin
          case (tok)
            TOK_DIGIT: state_nx = ST_NUM;
            TOK_LP: begin
              if (depth_q == DMAX) state_nx = ST_ERR;
              else begin
                state_nx = ST_START;
                depth_nx = depth_q + DONE;
              end
            end
            default: state_nx = ST_ERR;
          endcase
        end
        ST_NUM, ST_CLOSE: begin
          case (tok)
            TOK_DIGIT: state_nx = (state == ST_NUM) ? ST_NUM : ST_ERR;
            TOK_PLUS, TOK_MUL: state_nx = ST_START;
            TOK_RP: begin
              if (depth_q == '0) state_nx = ST_ERR;
              else begin
                state_nx = ST_CLOSE;
                depth_nx = depth_q - DONE;
              end
            end
            default: state_nx = ST_ERR;
          endcase
        end
        default: state_nx = ST_ERR;
      endcase
    end
    accept = bus.in_valid && (state_nx != ST_ERR);
    out_nx = ((state_nx == ST_NUM) || (state_nx == ST_CLOSE)) && (depth_nx == '0);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= ST_START;
      depth_q <= '0;
      out_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      depth_q <= depth_nx;
      out_q   <= out_nx;
    end
  end

  assign bus.out    = out_q;
  assign bus.Status = state;
  assign bus.depth  = depth_q;

`ifdef EXPR_STREAM_EVAL_EN
  localparam int LV = MAX_DEPTH + 1;
  localparam int XW = 2 * WIDTH + 1;

  logic [WIDTH-1:0] sum_q [LV];
  logic [WIDTH-1:0] prod_q[LV];
  logic [WIDTH-1:0] cur_q [LV];
  logic [WIDTH-1:0] sum_d [LV];
  logic [WIDTH-1:0] prod_d[LV];
  logic [WIDTH-1:0] cur_d [LV];
  logic [XW-1:0]    r_act, r_val;
  logic             act_ovf, val_ovf;
  logic [WIDTH-1:0] value_q;
  logic             ovf_q;

  // Exact a + b*c; anything above bit WIDTH-1 means the wrapped result lost bits.
  function automatic logic [XW-1:0] mac(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic [WIDTH-1:0] c);
    mac = XW'(a) + XW'(b) * XW'(c);
  endfunction

  always_comb begin
    for (int i = 0; i < LV; i++) begin
      sum_d[i]  = sum_q[i];
      prod_d[i] = prod_q[i];
      cur_d[i]  = cur_q[i];
    end
    r_act = '0;
    if (accept) begin
      case (tok)
        TOK_DIGIT: begin
          r_act = mac(WIDTH'(dig), cur_q[depth_q], WIDTH'(10));
          cur_d[depth_q] = r_act[WIDTH-1:0];
        end
        TOK_PLUS: begin
          r_act = mac(sum_q[depth_q], prod_q[depth_q], cur_q[depth_q]);
          sum_d[depth_q]  = r_act[WIDTH-1:0];
          prod_d[depth_q] = WIDTH'(1);
          cur_d[depth_q]  = '0;
        end
        TOK_MUL: begin
          r_act = mac('0, prod_q[depth_q], cur_q[depth_q]);
          prod_d[depth_q] = r_act[WIDTH-1:0];
          cur_d[depth_q]  = '0;
        end
        TOK_LP: begin
          sum_d[depth_q + DONE]  = '0;
          prod_d[depth_q + DONE] = WIDTH'(1);
          cur_d[depth_q + DONE]  = '0;
        end
        TOK_RP: begin
          r_act = mac(sum_q[depth_q], prod_q[depth_q], cur_q[depth_q]);
          cur_d[depth_q - DONE] = r_act[WIDTH-1:0];
        end
        default: r_act = '0;
      endcase
    end
    act_ovf = |r_act[XW-1:WIDTH];
    r_val   = mac(sum_d[0], prod_d[0], cur_d[0]);
    val_ovf = |r_val[XW-1:WIDTH];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < LV; i++) begin
        sum_q[i]  <= '0;
        prod_q[i] <= WIDTH'(1);
        cur_q[i]  <= '0;
      end
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < LV; i++) begin
        sum_q[i]  <= sum_d[i];
        prod_q[i] <= prod_d[i];
        cur_q[i]  <= cur_d[i];
      end
      if (out_nx) value_q <= r_val[WIDTH-1:0];
      ovf_q <= ovf_q | act_ovf | (out_nx & val_ovf);
    end
  end

  assign bus.value = value_q;
  assign bus.ovf   = ovf_q;
`else
  logic unused_dig;
  assign unused_dig = ^dig;
  assign bus.value  = {WIDTH{1'b0}};
  assign bus.ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_expr_stream_eval.sv
// Directed + random character streams against a reference model that
// queues the expected outputs for every step.
module tb_expr_stream_eval;

  localparam int W    = 8;
  localparam int MAXD = 4;
  localparam int MAXV = (1 << W) - 1;
`ifdef EXPR_STREAM_EVAL_EN
  localparam bit EVAL = 1'b1;
`else
  localparam bit EVAL = 1'b0;
`endif

  logic clk;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  logic [14:0] exp_q[$];

  expr_stream_eval_if #(.WIDTH(W), .MAX_DEPTH(MAXD)) bus ();

  expr_stream_eval #(.WIDTH(W), .MAX_DEPTH(MAXD)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_st, m_dep, m_val;
  bit m_ovf, m_out;
  int m_sum[MAXD+1], m_prod[MAXD+1], m_cur[MAXD+1];

  function automatic int wrapchk(int t);
    if (t > MAXV) m_ovf = 1'b1;
    return t & MAXV;
  endfunction

  task automatic model_reset();
    m_st = 0; m_dep = 0; m_val = 0; m_ovf = 1'b0; m_out = 1'b0;
    for (int i = 0; i <= MAXD; i++) begin
      m_sum[i] = 0; m_prod[i] = 1; m_cur[i] = 0;
    end
  endtask

  task automatic model_char(input byte c);
    bit legal;
    int ns, nd, d;
    if (m_st == 3) return;
    legal = 1'b1; ns = m_st; nd = m_dep; d = m_dep;
    if (c >= "0" && c <= "9") begin
      if (m_st == 2) legal = 1'b0; else ns = 1;
    end else if (c == "+" || c == "*") begin
      if (m_st == 0) legal = 1'b0; else ns = 0;
    end else if (c == "(") begin
      if (m_st != 0 || m_dep == MAXD) legal = 1'b0; else nd = m_dep + 1;
    end else if (c == ")") begin
      if (m_st == 0 || m_dep == 0) legal = 1'b0;
      else begin ns = 2; nd = m_dep - 1; end
    end else legal = 1'b0;
    if (!legal) begin
      m_st = 3; m_out = 1'b0;
      return;
    end
    if (c >= "0" && c <= "9") m_cur[d] = wrapchk(m_cur[d] * 10 + int'(c - "0"));
    else if (c == "+") begin
      m_sum[d] = wrapchk(m_sum[d] + m_prod[d] * m_cur[d]);
      m_prod[d] = 1; m_cur[d] = 0;
    end else if (c == "*") begin
      m_prod[d] = wrapchk(m_prod[d] * m_cur[d]);
      m_cur[d] = 0;
    end else if (c == "(") begin
      m_sum[d+1] = 0; m_prod[d+1] = 1; m_cur[d+1] = 0;
    end else m_cur[d-1] = wrapchk(m_sum[d] + m_prod[d] * m_cur[d]);
    m_st = ns; m_dep = nd;
    m_out = (ns == 1 || ns == 2) && nd == 0;
    if (m_out) m_val = wrapchk(m_sum[0] + m_prod[0] * m_cur[0]);
  endtask

  task automatic push_exp();
    logic [14:0] e;
    e[14]   = m_out;
    e[13:12] = 2'(m_st);
    e[11:9] = 3'(m_dep);
    e[8:1]  = EVAL ? 8'(m_val) : 8'd0;
    e[0]    = EVAL ? m_ovf : 1'b0;
    exp_q.push_back(e);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [14:0] e;
    total++;
    assert (exp_q.size() > 0) else begin
      bad++;
      $error("FAIL %s_queue: observed=0 expected=1", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_out"},    32'(bus.out),    32'(e[14]));
      chk({tag, "_status"}, 32'(bus.Status), 32'(e[13:12]));
      chk({tag, "_depth"},  32'(bus.depth),  32'(e[11:9]));
      chk({tag, "_value"},  32'(bus.value),  32'(e[8:1]));
      chk({tag, "_ovf"},    32'(bus.ovf),    32'(e[0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_char(input byte c, input string tag);
    @(negedge clk);
    bus.in = c;
    bus.in_valid = 1'b1;
    model_char(c);
    push_exp();
    @(posedge clk);
    #1;
    check_sb(tag);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) send_char(s[i], tag);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    bus.in = "x";
    bus.in_valid = 1'b0;
    push_exp();
    @(posedge clk);
    #1;
    check_sb(tag);
  endtask

  // Asserts clr away from any edge, checks outputs before the next edge,
  // then holds it across an edge with a valid digit present.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    clr = 1'b0;
    model_reset();
    push_exp();
    #1;
    check_sb({tag, "_async"});
    bus.in = "5";
    bus.in_valid = 1'b1;
    push_exp();
    @(posedge clk);
    #1;
    check_sb({tag, "_held"});
    @(negedge clk);
    bus.in_valid = 1'b0;
    clr = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  string alpha;
  int    sel;

  initial begin
    clr = 1'b1;
    bus.in = 8'h00;
    bus.in_valid = 1'b0;
    alpha = "0123456789+*()";

    do_reset("reset");

    send_str("1+23*5", "prec");
    chk("prec_final_value", 32'(bus.value), EVAL ? 32'd116 : 32'd0);
    chk("prec_final_status", 32'(bus.Status), 32'd1);

    do_reset("rst_paren");
    send_str("(1+2", "paren_open");
    chk("paren_inner_out", 32'(bus.out), 32'd0);
    send_str(")", "paren_close");
    chk("paren_close_status", 32'(bus.Status), 32'd2);
    send_str("*3", "paren_mul");
    chk("paren_final_value", 32'(bus.value), EVAL ? 32'd9 : 32'd0);

    do_reset("rst_err");
    send_str("1+*", "err_op");
    chk("err_status", 32'(bus.Status), 32'd3);
    send_str("4", "err_sticky");
    chk("err_frozen_value", 32'(bus.value), EVAL ? 32'd1 : 32'd0);

    do_reset("rst_deep");
    send_str("((((", "deep4");
    chk("deep_depth", 32'(bus.depth), 32'd4);
    send_str("(", "deep5");
    chk("deep_err", 32'(bus.Status), 32'd3);

    do_reset("rst_rp");
    send_str(")", "rp_at_0");
    chk("rp_depth", 32'(bus.depth), 32'd0);

    do_reset("rst_idle");
    send_str("7", "idle_a");
    for (int i = 0; i < 3; i++) idle("idle_gap");
    send_str("+8", "idle_b");
    chk("idle_value", 32'(bus.value), EVAL ? 32'd15 : 32'd0);

    do_reset("rst_wrap");
    send_str("16*16", "wrap");
    chk("wrap_ovf", 32'(bus.ovf), EVAL ? 32'd1 : 32'd0);
    send_str("+3", "wrap_more");
    do_reset("mid_clr");

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 12; k++) begin
        sel = $urandom_range(0, 17);
        if (sel < 14) send_char(alpha[sel], "rand");
        else if (sel < 16) send_char(alpha[$urandom_range(0, 9)], "rand_dig");
        else if (sel == 16) send_char("a", "rand_bad");
        else idle("rand_idle");
      end
      do_reset("rand_rst");
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/expr_stream_eval.md
# expr_stream_eval

Streaming ASCII arithmetic-expression recognizer, and optionally evaluator, for one character per clock. Successor to the single-digit expression FSM: it adds multi-digit operands, parentheses nested up to `MAX_DEPTH`, an input valid qualifier and a `WIDTH`-bit value result. Sits after the character source in the P1 expression datapath and reports validity on `out` and `Status`.

## Interface
- `WIDTH`, default 32: width of operand and result arithmetic.
- `MAX_DEPTH`, default 4: maximum parenthesis nesting depth (≥1).
- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `in`  in  8  ASCII character.
- `in_valid`  in  1  `in` is consumed on an edge only when this is 1.
- `out`  out  1  consumed prefix is a complete, legal expression.
- `Status`  out  2  FSM state (encoding under Operation).
- `depth`  out  $clog2(MAX_DEPTH+1)  current open-paren count.
- `value`  out  WIDTH  expression value (evaluation build only).
- `ovf`  out  1  sticky arithmetic wrap flag (evaluation build only).

## Operation
- Grammar: expr := term (op term)*; term := digit+ | '(' expr ')'; op ∈ {'+','*'}; digit ∈ '0'..'9'. Any other byte is illegal.
- States (`Status`):
  - `ST_START`=00: expects an operand.
  - `ST_NUM`=01: inside a number.
  - `ST_CLOSE`=10: after ')'.
  - `ST_ERR`=11.
- Transitions:
  - START: digit→NUM; '('→START with depth+1.
  - NUM: digit→NUM; op→START; ')'→CLOSE with depth−1.
  - CLOSE: op→START; ')'→CLOSE with depth−1.
- Everything else goes to ST_ERR. This includes:
  - an op or ')' in START;
  - a digit or '(' in CLOSE;
  - ')' at depth 0;
  - '(' at depth==MAX_DEPTH;
  - any illegal byte.
- ST_ERR is sticky until `clr`.
- `out` = (Status∈{NUM,CLOSE}) && depth==0. It is 0 in START and ERR.
- `in_valid`=0 leaves all state unchanged, regardless of `in`.
- Evaluation uses normal precedence ('*' binds tighter than '+'). The stack has MAX_DEPTH+1 levels; each level holds {sum, prod, cur}. Actions:
  - Level init: sum=0, prod=1, cur=0.
  - digit d: cur=cur*10+d.
  - '+': sum=sum+prod*cur; prod=1; cur=0.
  - '*': prod=prod*cur; cur=0.
  - '(': push a fresh level.
  - ')': pop; parent cur = inner sum+prod*cur.
- All arithmetic is mod 2^WIDTH. `ovf` sets whenever any true result exceeds 2^WIDTH−1.
- `value` = sum+prod*cur of level 0 whenever `out`=1. Otherwise it holds the last value that had `out`=1 (0 after reset).

## Timing
- Reset values: Status=ST_START, depth=0, out=0, value=0, ovf=0, all stack levels initialised.
- Latency is 1: a character accepted at edge k is reflected in every output after edge k. No combinational path from `in`/`in_valid` to any output.
- Entering ST_ERR freezes depth, value and ovf at their pre-error values.
- Asserting `clr` mid-expression aborts the expression immediately. The next accepted character after release starts a new expression.
- Wrap-around: depth never exceeds MAX_DEPTH or goes below 0. A would-be violation goes to ST_ERR instead.

## Configuration
- `EXPR_STREAM_EVAL_EN` defined: the evaluation stack, `value` and `ovf` are built as described.
- `EXPR_STREAM_EVAL_EN` undefined: recognizer only.
  - `value` is tied to 0 and `ovf` to 0.
  - No stack or multipliers are synthesised.
  - The FSM, `out`, `Status` and `depth` are identical in both builds.

## Structure
- `expr_pkg` holds:
  - state enum `expr_state_t` with the encodings above;
  - token class enum `expr_tok_t` {TOK_DIGIT, TOK_PLUS, TOK_MUL, TOK_LP, TOK_RP, TOK_BAD};
  - ASCII constants.
- Sub-module `expr_char_class`: combinational byte→{`expr_tok_t`, 4-bit digit value}. Instantiated once.
- Top holds the FSM, depth counter and the conditionally compiled stack.

## Test plan
- Input "1+23*5", one character per cycle with in_valid=1 → out=1 after the last edge, Status=01, value=116, ovf=0.
- Input "(1+2)*3" → out=0 while depth=1. After ')': out=1, Status=10. Final value=9.
- Input "1+*" → Status=11 after '*', out=0. A following "4" leaves Status=11 and value=1.
- MAX_DEPTH=4: input "(((((" → depth=4 after the fourth char, Status=11 after the fifth. Separately, input ")" from reset → Status=11 and depth=0.
- Input "7", then 3 idle cycles with in_valid=0 and in="x", then "+8" → no error; value=15.
- WIDTH=8: input "16*16" → value=0, ovf=1. Then assert `clr` low mid-stream → all outputs return to reset values asynchronously.
